// File: rtl/combination_sequencer_pkg.sv
// comb_seq_pkg: shared types and encodings for the combination sequencer.
//   state_e      - sequencer FSM states
//   LUT_*        - lut_WrRd command encodings
//   MODE_*       - cfg_mode encodings
//   abortable()  - states from which abort diverts to RESET
package comb_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_LUT_WR,
    S_LUT_GAP,
    S_CAPTURE,
    S_READOUT,
    S_DRAIN,
    S_RESET,
    S_DONE
  } state_e;

  localparam logic [1:0] LUT_WR   = 2'b10;
  localparam logic [1:0] LUT_RD   = 2'b01;
  localparam logic [1:0] LUT_IDLE = 2'b00;

  localparam logic [1:0] MODE_HIST = 2'b10;
  localparam logic [1:0] MODE_FIFO = 2'b01;

  // RESET and DONE already lead back to IDLE, so abort is only honoured
  // between WAIT_RDY and DRAIN.
  function automatic logic abortable(state_e s);
    return s inside {S_WAIT_RDY, S_LUT_WR, S_LUT_GAP, S_CAPTURE, S_READOUT, S_DRAIN};
  endfunction

endpackage

// File: rtl/combination_sequencer_if.sv
// Result stream (AXI-Stream style) between the sequencer and the host DMA.
//   tdata  - result word
//   tvalid - word present
//   tlast  - final word of the run
//   tready - sink accepts the word
interface combination_sequencer_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (output tdata, tvalid, tlast, input  tready);
  modport slave  (input  tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/combination_sequencer_skid.sv
// comb_seq_skid: 2-entry output buffer between the readout path and the
// result stream. All outputs come straight from registers.
//   push/push_data - write one entry (caller guarantees not full unless popping)
//   pop            - consume the head entry (caller guarantees not empty)
//   flush          - drop all entries; wins over push/pop in the same cycle
//   occ            - entries held (0..2)
//   head/valid     - oldest entry and its presence
module comb_seq_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   occ,
  output logic [W-1:0] head,
  output logic         valid
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      // push+pop together leaves occupancy unchanged
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (occ != 2'd0);

endmodule

// File: rtl/combination_sequencer.sv
// combination_sequencer: autonomous master for the combination module.
// Sequence per run: wait ready -> write LUT_DEPTH LUT entries (each followed
// by a one-cycle idle gap) -> capture for N cycles -> read back words into a
// 2-entry buffer that feeds the result stream -> drain -> reset the
// combination module -> done pulse.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   start, abort          - run trigger (IDLE only), abort level
//   cfg_*                 - run configuration, latched at start
//   busy, done, err       - status (done is a pulse, err sticky until start)
//   window..reset_comb    - control to the combination module
//   lut_WrRd/addr/dat_i   - LUT write port
//   ready_o..reset_comb_done - returns from the combination module
//   m                     - result stream master
module combination_sequencer
  import comb_seq_pkg::*;
#(
  parameter int CHANNELS    = 16,
  parameter int LUT_DEPTH   = 64,
  parameter int CNT_WIDTH   = 32,
  parameter int ACK_TIMEOUT = 1024,
  localparam int FW = $clog2(CHANNELS + 1),
  localparam int AW = $clog2(LUT_DEPTH),
  localparam int CW = $clog2(CHANNELS),
  localparam int TW = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [63:0]          cfg_window,
  input  logic [FW-1:0]        cfg_filter_min,
  input  logic [FW-1:0]        cfg_filter_max,
  input  logic [1:0]           cfg_mode,
  input  logic [31:0]          cfg_capture_cycles,
  input  logic [16:0]          cfg_read_count,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [63:0]          window,
  output logic [FW-1:0]        filter_min,
  output logic [FW-1:0]        filter_max,
  output logic                 select_comb_fifo,
  output logic                 capture_enable,
  output logic                 start_reading,
  output logic                 ready_i,
  output logic                 reset_comb,
  output logic [1:0]           lut_WrRd,
  output logic [AW-1:0]        lut_addr,
  output logic [CHANNELS:0]    lut_dat_i,
  input  logic                 ready_o,
  input  logic                 lut_ack,
  input  logic                 comb_out_vd,
  input  logic [CNT_WIDTH-1:0] comb_count,
  input  logic                 reset_comb_done,
  combination_sequencer_if.master m
);

  // Entry i (1..CHANNELS) enables channel i-1; entry 0 and the tail are unused.
  function automatic logic [CHANNELS:0] lut_entry(logic [AW-1:0] i);
    logic [CHANNELS:0] e;
    e = '0;
    if (int'(i) >= 1 && int'(i) <= CHANNELS) begin
      e[CHANNELS] = 1'b1;
      e[CW-1:0]   = CW'(int'(i) - 1);
    end
    return e;
  endfunction

  state_e        state;
  logic [63:0]   lw;
  logic [FW-1:0] lfmin, lfmax;
  logic [1:0]    lmode;
  logic [31:0]   lcap;
  logic [16:0]   lrd;
  logic [31:0]   cap_cnt;
  logic [16:0]   acc;
  logic [TW-1:0] tmo_cnt;

  logic [31:0]          cap_eff;
  logic                 push, pop, flush;
  logic [1:0]           occ;
  logic [CNT_WIDTH:0]   sk_head;
  logic                 sk_valid;

  assign cap_eff = (lcap == 32'd0) ? 32'd1 : lcap;

  // Built from registers only, so m.tready never reaches ready_i.
  assign ready_i = (state == S_READOUT) && (occ != 2'd2) && (acc < lrd);
  assign push    = comb_out_vd && ready_i;
  assign pop     = sk_valid && m.tready;
  assign flush   = abort && abortable(state);

  comb_seq_skid #(.W(CNT_WIDTH + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({(acc == lrd - 17'd1), comb_count}),
    .pop       (pop),
    .flush     (flush),
    .occ       (occ),
    .head      (sk_head),
    .valid     (sk_valid)
  );

  assign {m.tlast, m.tdata} = sk_head;
  assign m.tvalid           = sk_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      window           <= '0;
      filter_min       <= '0;
      filter_max       <= '0;
      select_comb_fifo <= 1'b0;
      capture_enable   <= 1'b0;
      start_reading    <= 1'b0;
      reset_comb       <= 1'b0;
      lut_WrRd         <= LUT_IDLE;
      lut_addr         <= '0;
      lut_dat_i        <= '0;
      lw               <= '0;
      lfmin            <= '0;
      lfmax            <= '0;
      lmode            <= '0;
      lcap             <= '0;
      lrd              <= '0;
      cap_cnt          <= '0;
      acc              <= '0;
      tmo_cnt          <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        err           <= 1'b1;
        start_reading <= 1'b0;
        lut_WrRd      <= LUT_IDLE;
        reset_comb    <= 1'b1;
        tmo_cnt       <= '0;
        state         <= S_RESET;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            lw    <= cfg_window;
            lfmin <= cfg_filter_min;
            lfmax <= cfg_filter_max;
            lmode <= cfg_mode;
            lcap  <= cfg_capture_cycles;
            lrd   <= cfg_read_count;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= S_WAIT_RDY;
          end
          S_WAIT_RDY: if (ready_o) begin
            window           <= lw;
            filter_min       <= lfmin;
            filter_max       <= lfmax;
            select_comb_fifo <= (lmode == MODE_FIFO);
            lut_WrRd         <= LUT_WR;
            lut_addr         <= '0;
            lut_dat_i        <= lut_entry('0);
            tmo_cnt          <= '0;
            state            <= S_LUT_WR;
          end
          S_LUT_WR: begin
            if (lut_ack) begin
              lut_WrRd <= LUT_IDLE;
              state    <= S_LUT_GAP;
            end else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
              err        <= 1'b1;
              lut_WrRd   <= LUT_IDLE;
              reset_comb <= 1'b1;
              tmo_cnt    <= '0;
              state      <= S_RESET;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          S_LUT_GAP: begin
            if (lut_addr == AW'(LUT_DEPTH - 1)) begin
              capture_enable <= 1'b1;
              cap_cnt        <= 32'd1;
              state          <= S_CAPTURE;
            end else begin
              lut_addr  <= lut_addr + 1'b1;
              lut_dat_i <= lut_entry(lut_addr + 1'b1);
              lut_WrRd  <= LUT_WR;
              tmo_cnt   <= '0;
              state     <= S_LUT_WR;
            end
          end
          S_CAPTURE: begin
            // cap_cnt counts cycles already spent here, starting at 1
            if (cap_cnt == cap_eff) begin
              if (lrd == 17'd0) begin
                reset_comb <= 1'b1;
                tmo_cnt    <= '0;
                state      <= S_RESET;
              end else begin
                start_reading <= 1'b1;
                acc           <= '0;
                state         <= S_READOUT;
              end
            end else begin
              cap_cnt <= cap_cnt + 32'd1;
            end
          end
          S_READOUT: if (push) begin
            acc <= acc + 17'd1;
            if (acc == lrd - 17'd1) begin
              start_reading <= 1'b0;
              state         <= S_DRAIN;
            end
          end
          S_DRAIN: if (occ == 2'd0) begin
            reset_comb <= 1'b1;
            tmo_cnt    <= '0;
            state      <= S_RESET;
          end
          S_RESET: begin
            if (reset_comb_done || tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
              if (!reset_comb_done) err <= 1'b1;
              reset_comb       <= 1'b0;
              capture_enable   <= 1'b0;
              window           <= '0;
              filter_min       <= '0;
              filter_max       <= '0;
              select_comb_fifo <= 1'b0;
              lut_addr         <= '0;
              lut_dat_i        <= '0;
              done             <= 1'b1;
              state            <= S_DONE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_combination_sequencer.sv
module tb_combination_sequencer;
  import comb_seq_pkg::*;

  localparam int LD = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, abort = 1'b0;
  logic [63:0] cfg_window = '0;
  logic [4:0]  cfg_filter_min = 5'd2, cfg_filter_max = 5'd9;
  logic [1:0]  cfg_mode = '0;
  logic [31:0] cfg_capture_cycles = '0;
  logic [16:0] cfg_read_count = '0;
  logic        busy, done, err;
  logic [63:0] window;
  logic [4:0]  filter_min, filter_max;
  logic        select_comb_fifo, capture_enable, start_reading, ready_i, reset_comb;
  logic [1:0]  lut_WrRd;
  logic [5:0]  lut_addr;
  logic [16:0] lut_dat_i;
  logic        ready_o = 1'b1;
  logic        lut_ack, comb_out_vd, reset_comb_done;
  logic [31:0] comb_count;

  logic ack_en = 1'b1, bp_en = 1'b0, mon_clr = 1'b0;
  int   cur_rd = 0;
  int   n_chk = 0, n_err = 0;

  combination_sequencer_if #(.W(32)) m_if ();

  combination_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_window(cfg_window), .cfg_filter_min(cfg_filter_min), .cfg_filter_max(cfg_filter_max),
    .cfg_mode(cfg_mode), .cfg_capture_cycles(cfg_capture_cycles), .cfg_read_count(cfg_read_count),
    .busy(busy), .done(done), .err(err), .window(window), .filter_min(filter_min),
    .filter_max(filter_max), .select_comb_fifo(select_comb_fifo), .capture_enable(capture_enable),
    .start_reading(start_reading), .ready_i(ready_i), .reset_comb(reset_comb),
    .lut_WrRd(lut_WrRd), .lut_addr(lut_addr), .lut_dat_i(lut_dat_i), .ready_o(ready_o),
    .lut_ack(lut_ack), .comb_out_vd(comb_out_vd), .comb_count(comb_count),
    .reset_comb_done(reset_comb_done), .m(m_if)
  );

  // ---- combination module / sink model ----
  int          rc_cnt;
  logic [31:0] src_val;
  assign lut_ack         = ack_en && (lut_WrRd == 2'b10);
  assign comb_out_vd     = 1'b1;
  assign comb_count      = src_val;
  assign reset_comb_done = (rc_cnt >= 3);

  always @(negedge clk) m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;

  // ---- monitor ----
  int          wr_cnt, beats, data_err, last_cnt, last_err, done_cnt, cap_cyc;
  int          acc_cnt, occ_m, occ_viol, stab_err;
  logic        seen_rd, rc_seen, sel_seen, hold_v;
  logic [63:0] win_seen;
  logic [31:0] hold_d;
  logic [16:0] lut_mem [LD];
  logic        push_m, pop_m;
  assign push_m = comb_out_vd && ready_i;
  assign pop_m  = m_if.tvalid && m_if.tready;

  always @(posedge clk) begin
    rc_cnt <= (!rst_n || !reset_comb) ? 0 : rc_cnt + 1;
    if (mon_clr) begin
      wr_cnt <= 0; beats <= 0; data_err <= 0; last_cnt <= 0; last_err <= 0;
      done_cnt <= 0; cap_cyc <= 0; acc_cnt <= 0; occ_m <= 0; occ_viol <= 0;
      stab_err <= 0; seen_rd <= 1'b0; rc_seen <= 1'b0; sel_seen <= 1'b0;
      hold_v <= 1'b0; win_seen <= '0; src_val <= 32'h1000_0000;
      for (int i = 0; i < LD; i++) lut_mem[i] <= '1;
    end else begin
      if (lut_WrRd == 2'b10 && lut_ack) begin
        lut_mem[lut_addr] <= lut_dat_i;
        wr_cnt <= wr_cnt + 1;
        if (wr_cnt == 0) begin
          win_seen <= window;
          sel_seen <= select_comb_fifo;
        end
      end
      if (push_m) begin
        src_val <= src_val + 32'd1;
        acc_cnt <= acc_cnt + 1;
      end
      if (pop_m) begin
        if (m_if.tdata != 32'h1000_0000 + 32'(beats)) data_err <= data_err + 1;
        if (m_if.tlast) last_cnt <= last_cnt + 1;
        if (m_if.tlast != (beats == cur_rd - 1)) last_err <= last_err + 1;
        beats <= beats + 1;
      end
      occ_m <= occ_m + int'(push_m) - int'(pop_m);
      if (ready_i && occ_m == 2) occ_viol <= occ_viol + 1;
      hold_v <= m_if.tvalid && !m_if.tready;
      hold_d <= m_if.tdata;
      if (hold_v && (!m_if.tvalid || m_if.tdata != hold_d)) stab_err <= stab_err + 1;
      if (capture_enable && !start_reading && !reset_comb && !seen_rd) cap_cyc <= cap_cyc + 1;
      if (start_reading) seen_rd <= 1'b1;
      if (reset_comb) rc_seen <= 1'b1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  // ---- helpers ----
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic outs_any();
    return |{busy, done, err, window, filter_min, filter_max, select_comb_fifo,
             capture_enable, start_reading, ready_i, reset_comb, lut_WrRd, lut_addr,
             lut_dat_i, m_if.tdata, m_if.tvalid, m_if.tlast};
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  // Pulses start for one cycle; returns on the negedge after the pulse.
  task automatic go(logic [1:0] mode, logic [31:0] cap, logic [16:0] rd, logic [63:0] win);
    cfg_mode = mode; cfg_capture_cycles = cap; cfg_read_count = rd; cfg_window = win;
    cur_rd = int'(rd);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done_cnt != 0), 1);
  endtask

  // ---- directed tests ----
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs_any(), 0);
    rst_n = 1'b1;
    tick(2);

    // Histogram run: full LUT, 1000 capture cycles, 65536 beats
    clr();
    go(MODE_HIST, 32'd1000, 17'h10000, 64'hDEAD_BEEF_0123_4567);
    chk("start_busy", busy, 1);
    chk("wait_rdy_lut_idle", lut_WrRd, 2'b00);
    tick();
    chk("lat_lut_wr", lut_WrRd, 2'b10);
    chk("lat_lut_addr", lut_addr, 0);
    wait_done(80000);
    chk("hist_wr_cnt", wr_cnt, 64);
    chk("hist_lut0", lut_mem[0], 17'h00000);
    chk("hist_lut5", lut_mem[5], 17'h10004);
    chk("hist_lut16", lut_mem[16], 17'h1000F);
    chk("hist_lut17", lut_mem[17], 17'h00000);
    chk("hist_lut63", lut_mem[63], 17'h00000);
    chk("hist_window", win_seen, 64'hDEAD_BEEF_0123_4567);
    chk("hist_sel", sel_seen, 0);
    chk("hist_cap_cyc", cap_cyc, 1000);
    chk("hist_beats", beats, 65536);
    chk("hist_data_err", data_err, 0);
    chk("hist_last_cnt", last_cnt, 1);
    chk("hist_last_pos", last_err, 0);
    chk("hist_err", err, 0);
    tick(2);
    chk("hist_done_once", done_cnt, 1);
    chk("hist_idle_busy", busy, 0);

    // LUT ack timeout
    clr();
    ack_en = 1'b0;
    go(MODE_FIFO, 32'd10, 17'd8, 64'h1);
    n = 0;
    while (lut_WrRd != 2'b10 && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (!err && n < 2000) begin @(negedge clk); n++; end
    chk("tmo_cycles", n, 1024);
    wait_done(200);
    chk("tmo_err", err, 1);
    chk("tmo_reset_comb", rc_seen, 1);
    chk("tmo_beats", beats, 0);
    chk("tmo_wr_cnt", wr_cnt, 0);
    ack_en = 1'b1;
    tick(2);

    // Backpressure in FIFO mode
    clr();
    bp_en = 1'b1;
    go(MODE_FIFO, 32'd20, 17'd1024, 64'h55);
    chk("err_cleared_by_start", err, 0);
    wait_done(20000);
    bp_en = 1'b0;
    chk("bp_sel", sel_seen, 1);
    chk("bp_beats", beats, 1024);
    chk("bp_data_err", data_err, 0);
    chk("bp_last_cnt", last_cnt, 1);
    chk("bp_last_pos", last_err, 0);
    chk("bp_occ_viol", occ_viol, 0);
    chk("bp_stable", stab_err, 0);
    chk("bp_err", err, 0);
    tick(2);

    // Abort at accepted word 100
    clr();
    go(MODE_FIFO, 32'd5, 17'd1024, 64'h77);
    n = 0;
    while (acc_cnt < 100 && n < 2000) begin @(negedge clk); n++; end
    chk("abort_reach100", acc_cnt, 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_start_reading", start_reading, 0);
    chk("abort_reset_comb", reset_comb, 1);
    chk("abort_err", err, 1);
    chk("abort_flushed", m_if.tvalid, 0);
    chk("abort_ready_i", ready_i, 0);
    wait_done(200);
    chk("abort_data_err", data_err, 0);
    chk("abort_no_last", last_cnt, 0);
    tick(2);

    // Async reset in the middle of capture, then a clean run
    clr();
    go(MODE_HIST, 32'd1000, 17'd16, 64'h99);
    n = 0;
    while (!capture_enable && n < 400) begin @(negedge clk); n++; end
    tick(5);
    chk("pre_rst_capture", capture_enable, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_outs", outs_any(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
    clr();
    go(MODE_HIST, 32'd5, 17'd16, 64'hAB);
    wait_done(1000);
    chk("post_rst_wr_cnt", wr_cnt, 64);
    chk("post_rst_beats", beats, 16);
    chk("post_rst_data_err", data_err, 0);
    chk("post_rst_last_pos", last_err, 0);
    chk("post_rst_err", err, 0);
    tick(2);

    // Zero read count and zero capture cycles
    clr();
    go(MODE_HIST, 32'd0, 17'd0, 64'h3);
    wait_done(500);
    chk("zero_cap_cyc", cap_cyc, 1);
    chk("zero_beats", beats, 0);
    chk("zero_reset_comb", rc_seen, 1);
    chk("zero_err", err, 0);
    tick(2);
    chk("zero_done_once", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/combination_sequencer.md
# combination_sequencer

Synthesizable master for `combination_interface` that runs a full combination acquisition autonomously, with no Wishbone host in the loop. It loads the channel-selector LUT and applies window/filter/mode, then enables capture for a programmed number of cycles. It then reads back the histogram or FIFO words, streams them out on a 32-bit AXI-Stream master, and finally resets the combination module. It sits between a control/status register block and the combination module; its output stream feeds the host DMA.

## Interface
- `CHANNELS`, 16: input channels; LUT entries 1..CHANNELS map to channels 0..CHANNELS-1.
- `LUT_DEPTH`, 64: LUT entries written per run.
- `CNT_WIDTH`, 32: width of `comb_count` and `m_tdata`.
- `ACK_TIMEOUT`, 1024: maximum cycles to wait for `lut_ack` or `reset_comb_done`.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; ignored unless IDLE.
- `abort` in 1: level; forces the RESET path from any active state.
- `cfg_window` in 64, `cfg_filter_min`/`cfg_filter_max` in $clog2(CHANNELS+1), `cfg_mode` in 2 (2'b10 histogram, 2'b01 FIFO), `cfg_capture_cycles` in 32, `cfg_read_count` in 17: all sampled at `start`.
- `busy` out 1, `done` out 1 (1-cycle pulse), `err` out 1 (sticky until next `start`).
- `window`, `filter_min`, `filter_max`, `select_comb_fifo`, `capture_enable`, `start_reading`, `ready_i`, `reset_comb` out: driven to the combination module.
- `lut_WrRd` out 2, `lut_addr` out $clog2(LUT_DEPTH), `lut_dat_i` out CHANNELS+1: LUT write port. Bit CHANNELS is valid; `[$clog2(CHANNELS)-1:0]` is the channel.
- `ready_o`, `lut_ack`, `comb_out_vd`, `comb_count`[CNT_WIDTH], `reset_comb_done` in: returned from the combination module.
- `m_tdata` out CNT_WIDTH, `m_tvalid` out 1, `m_tlast` out 1, `m_tready` in 1: result stream.

## Operation
- States: IDLE → WAIT_RDY → LUT_WR ↔ LUT_GAP → CAPTURE → READOUT → DRAIN → RESET → DONE → IDLE.
- **IDLE**: all control outputs are 0. `start` latches the configuration, clears `err` and enters WAIT_RDY.
- **WAIT_RDY**: wait for `ready_o`. Then drive `window`, `filter_*` and `select_comb_fifo` from the latched configuration; they hold until RESET exits.
- **LUT_WR**:
  - Drive `lut_WrRd`=2'b10 and `lut_addr`=i.
  - `lut_dat_i` = {1'b1, i-1} for 1≤i≤CHANNELS, otherwise 0.
  - Hold until `lut_ack`, then go to LUT_GAP.
- **LUT_GAP**: `lut_WrRd`=2'b00 for exactly one cycle. Then i+1, or CAPTURE after entry LUT_DEPTH-1.
- **CAPTURE**: `capture_enable`=1 for max(`cfg_capture_cycles`,1) cycles.
- **READOUT**:
  - `start_reading`=1; `capture_enable` stays 1.
  - A word is accepted when `comb_out_vd` && `ready_i`.
  - After `cfg_read_count` accepted words, go to DRAIN. If `cfg_read_count`=0, skip directly to RESET.
- **DRAIN**: `start_reading`=0 and `ready_i`=0; wait for the output buffer to empty.
- **RESET**:
  - `reset_comb`=1 until `reset_comb_done`.
  - Then drop `reset_comb` and `capture_enable` in the same cycle and go to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- **Timeouts**: if `lut_ack` or `reset_comb_done` is absent for ACK_TIMEOUT cycles, set `err`. A timeout in LUT_WR goes to RESET; a timeout in RESET goes to DONE.
- **abort**:
  - From WAIT_RDY through DRAIN: clear the output buffer, set `err`, go to RESET. Any pending words are discarded.
  - Ignored in RESET and DONE.
- `m_tlast`=1 on the word with index `cfg_read_count`-1.

## Timing
- Every output resets to 0 asynchronously on `rst_n` low; the FSM returns to IDLE.
- Synchronous release applies on the first `clk` edge with `rst_n` high.
- **Output buffer**: 2 entries.
  - `ready_i` = (state==READOUT) && (occupancy≠2) && (accepted<`cfg_read_count`).
  - `ready_i` is decoded from registers only; there is no combinational path from `m_tready`.
- **Throughput**: 1 word/cycle when `m_tready`=1. `m_tdata` appears 1 cycle after acceptance.
- **Stream rules**:
  - Simultaneous push and pop leaves occupancy unchanged.
  - `m_tvalid`/`m_tdata` are stable while `m_tready`=0.
- `busy`=1 in every state except IDLE.
- Latency from `start` to the first LUT write is 2 cycles when `ready_o` is already high.

## Structure
- Package `comb_seq_pkg` holds:
  - the state enum;
  - LUT_WR=2'b10, LUT_RD=2'b01, LUT_IDLE=2'b00;
  - MODE_HIST=2'b10, MODE_FIFO=2'b01.
- Sub-module `comb_seq_skid`: the 2-entry buffer, exposing occupancy, push, pop and flush. The FSM and counters live in the top module.

## Test plan
- **Histogram run**: `cfg_mode`=2'b10, `cfg_capture_cycles`=1000, `cfg_read_count`=65536, `m_tready`=1 → 64 LUT writes with entry 5 = {1,4} and entry 0 = 0; exactly 65536 beats; `m_tlast` only on beat 65535; one `done` pulse; `err`=0.
- **Backpressure**: `m_tready` random at 50% in FIFO mode with `cfg_read_count`=1024 → no lost or duplicated words against the model; `ready_i` never high with occupancy 2.
- **LUT timeout**: `lut_ack` never asserted → `err`=1 after 1024 cycles; `reset_comb` asserted; `done` pulse; no stream beats.
- **Abort mid-READOUT** at word 100 → buffer flushed, `start_reading`=0 next cycle, RESET entered, `err`=1.
- **Async reset mid-CAPTURE** (`rst_n` low for 3 cycles) → all outputs 0 immediately; a new `start` runs a clean sequence.
- **Zero counts**: `cfg_read_count`=0 and `cfg_capture_cycles`=0 → capture lasts 1 cycle; no beats; RESET and then `done`.
